// File: rtl/decode_and_execute_if.sv
// Operand/select bundle into the ALU stage and the registered result back out.
// No handshake: a new operation is presented every cycle.
interface decode_and_execute_if;
  logic [3:0] rs;
  logic [3:0] rt;
  logic [2:0] sel;
  logic [3:0] rd;

  modport master (output rs, output rt, output sel, input rd);
  modport slave  (input rs, input rt, input sel, output rd);
endinterface

// File: rtl/decode_and_execute.sv
// 4-bit ALU stage: decodes sel, computes add/sub/logic/shift/compare, registers rd.
// Latency 1 cycle; no backpressure, accepts a new operation every cycle.
module decode_and_execute (
  input  logic                  clk,
  input  logic                  rst_n,
  decode_and_execute_if.slave   bus
);

  logic       sub;
  logic [3:0] addb;
  logic [3:0] carry;
  logic [3:0] sum;
  logic [3:0] and_res;
  logic [3:0] or_res;
  logic [3:0] asr_res;
  logic [3:0] rol_res;
  logic       lt;
  logic       eq;
  logic [3:0] res;

  // Subtract reuses the adder as rs + ~rt + 1.
  assign sub      = (bus.sel == 3'b000);
  assign addb     = sub ? ~bus.rt : bus.rt;
  assign carry[0] = sub;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_rca
      assign sum[i] = bus.rs[i] ^ addb[i] ^ carry[i];
      if (i < 3) begin : g_carry
        assign carry[i+1] = (bus.rs[i] & addb[i]) | (carry[i] & (bus.rs[i] ^ addb[i]));
      end
    end
  endgenerate

  assign and_res = bus.rs & bus.rt;
  assign or_res  = bus.rs | bus.rt;
  assign asr_res = {bus.rt[3], bus.rt[3:1]};
  assign rol_res = {bus.rs[2:0], bus.rs[3]};
  assign lt      = (bus.rs < bus.rt);
  assign eq      = (bus.rs == bus.rt);

  always_comb begin
    res = 4'b0000;
    case (bus.sel)
      3'b000:  res = sum;
      3'b001:  res = sum;
      3'b010:  res = and_res;
      3'b011:  res = or_res;
      3'b100:  res = asr_res;
      3'b101:  res = rol_res;
      3'b110:  res = {3'b101, lt};
      3'b111:  res = {3'b111, eq};
      default: res = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd <= 4'b0000;
    end else begin
      bus.rd <= res;
    end
  end

endmodule

// File: tb/tb_decode_and_execute.sv
// Directed vector table plus hand-written reset/back-to-back sequences for decode_and_execute.
module tb_decode_and_execute;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_and_execute_if bus ();

  decode_and_execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: rd=%b expected %b", name, got, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] sel, input logic [3:0] rs,
                         input logic [3:0] rt, input logic [3:0] exp);
    vec_t v;
    v.name = name;
    v.sel  = sel;
    v.rs   = rs;
    v.rt   = rt;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  logic [3:0] b2b_exp [8];
  logic [3:0] prev_exp;

  initial begin
    add_vec("sub_4_2",    3'b000, 4'd4,  4'd2,  4'd2);
    add_vec("sub_15_12",  3'b000, 4'd15, 4'd12, 4'd3);
    add_vec("sub_15_15",  3'b000, 4'd15, 4'd15, 4'd0);
    add_vec("sub_2_4",    3'b000, 4'd2,  4'd4,  4'd14);
    add_vec("add_13_2",   3'b001, 4'd13, 4'd2,  4'd15);
    add_vec("add_15_1",   3'b001, 4'd15, 4'd1,  4'd0);
    add_vec("and_c_a",    3'b010, 4'b1100, 4'b1010, 4'b1000);
    add_vec("and_f_0",    3'b010, 4'b1111, 4'b0000, 4'b0000);
    add_vec("and_f_f",    3'b010, 4'b1111, 4'b1111, 4'b1111);
    add_vec("or_c_a",     3'b011, 4'b1100, 4'b1010, 4'b1110);
    add_vec("or_0_f",     3'b011, 4'b0000, 4'b1111, 4'b1111);
    add_vec("or_0_0",     3'b011, 4'b0000, 4'b0000, 4'b0000);
    add_vec("asr_9",      3'b100, 4'b0000, 4'b1001, 4'b1100);
    add_vec("asr_8",      3'b100, 4'b0000, 4'b1000, 4'b1100);
    add_vec("asr_2",      3'b100, 4'b0000, 4'b0010, 4'b0001);
    add_vec("asr_1",      3'b100, 4'b0000, 4'b0001, 4'b0000);
    add_vec("asr_9_rsf",  3'b100, 4'b1111, 4'b1001, 4'b1100);
    add_vec("asr_8_rsf",  3'b100, 4'b1111, 4'b1000, 4'b1100);
    add_vec("asr_2_rsf",  3'b100, 4'b1111, 4'b0010, 4'b0001);
    add_vec("asr_1_rsf",  3'b100, 4'b1111, 4'b0001, 4'b0000);
    add_vec("rol_9",      3'b101, 4'b1001, 4'b0000, 4'b0011);
    add_vec("rol_8",      3'b101, 4'b1000, 4'b0000, 4'b0001);
    add_vec("rol_9_rtf",  3'b101, 4'b1001, 4'b1111, 4'b0011);
    add_vec("rol_8_rtf",  3'b101, 4'b1000, 4'b1111, 4'b0001);
    add_vec("slt_2_4",    3'b110, 4'd2, 4'd4, 4'b1011);
    add_vec("slt_6_4",    3'b110, 4'd6, 4'd4, 4'b1010);
    add_vec("slt_4_4",    3'b110, 4'd4, 4'd4, 4'b1010);
    add_vec("seq_6_6",    3'b111, 4'd6, 4'd6, 4'b1111);
    add_vec("seq_6_7",    3'b111, 4'd6, 4'd7, 4'b1110);

    // rs=1001, rt=0110 through sel 000..111; ASR of 0110 is 0011.
    b2b_exp[0] = 4'b0011;
    b2b_exp[1] = 4'b1111;
    b2b_exp[2] = 4'b0000;
    b2b_exp[3] = 4'b1111;
    b2b_exp[4] = 4'b0011;
    b2b_exp[5] = 4'b0011;
    b2b_exp[6] = 4'b1010;
    b2b_exp[7] = 4'b1110;

    // Reset applied before any clock edge must clear rd.
    rst_n   = 1'b0;
    bus.sel = 3'b001;
    bus.rs  = 4'd7;
    bus.rt  = 4'd7;
    #1;
    check("reset_async_t0", bus.rd, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", bus.rd, 4'b0000);

    @(negedge clk);
    rst_n   = 1'b1;
    bus.sel = 3'b001;
    bus.rs  = 4'd3;
    bus.rt  = 4'd2;
    @(posedge clk);
    #1;
    check("reset_release_add", bus.rd, 4'd5);

    foreach (vecs[k]) begin
      @(negedge clk);
      bus.sel = vecs[k].sel;
      bus.rs  = vecs[k].rs;
      bus.rt  = vecs[k].rt;
      @(posedge clk);
      #1;
      check(vecs[k].name, bus.rd, vecs[k].exp);
    end
    prev_exp = vecs[vecs.size()-1].exp;

    // Back-to-back: new op each cycle, result visible only after its own edge.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      bus.sel = 3'(k);
      bus.rs  = 4'b1001;
      bus.rt  = 4'b0110;
      #1;
      check($sformatf("b2b_hold_%0d", k), bus.rd, prev_exp);
      @(posedge clk);
      #1;
      check($sformatf("b2b_sel_%0d", k), bus.rd, b2b_exp[k]);
      prev_exp = b2b_exp[k];
      if (k == 3) begin
        // Mid-cycle reset: rd drops at once, no clock edge involved.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("b2b_reset_async", bus.rd, 4'b0000);
        @(posedge clk);
        #1;
        check("b2b_reset_held", bus.rd, 4'b0000);
        prev_exp = 4'b0000;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
